// File: rtl/pred_update_queue.sv
// Branch-predictor update queue: buffers up to two resolved branches per cycle from commit
// and drains one entry per cycle into the predictor's registered update ports.
module pred_update_queue #(
  parameter int DEPTH  = 8,
  parameter int PTRLEN = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid_0,
  input  logic [31:0]       push_pc_0,
  input  logic [2:0]        push_type_0,
  input  logic              push_taken_0,
  input  logic [31:0]       push_target_0,
  input  logic              push_mispred_0,
  input  logic              push_valid_1,
  input  logic [31:0]       push_pc_1,
  input  logic [2:0]        push_type_1,
  input  logic              push_taken_1,
  input  logic [31:0]       push_target_1,
  input  logic              push_mispred_1,
  output logic              push_ready,
  output logic              update_orien_en,
  output logic [31:0]       retire_pc,
  output logic              right_orien,
  output logic              branch_mistaken,
  output logic [31:0]       wrong_pc,
  output logic [31:0]       right_target,
  output logic [2:0]        ins_type_w,
  output logic [PTRLEN:0]   occupancy
);

  localparam logic [2:0]      BR_NOP    = 3'd0;
  localparam logic [2:0]      BR_COND   = 3'd1;
  localparam logic [PTRLEN:0] READY_MAX = (PTRLEN+1)'(DEPTH - 2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [2:0]  typ;
    logic        taken;
    logic        mispred;
  } entry_t;

  entry_t              mem_r [DEPTH];
  logic [PTRLEN-1:0]   wr_ptr_r;
  logic [PTRLEN-1:0]   rd_ptr_r;

  entry_t              lane0_s;
  entry_t              lane1_s;
  entry_t              head_s;
  logic                useful0_s;
  logic                useful1_s;
  logic                pop_s;
  logic [PTRLEN-1:0]   wr_ptr1_s;
  logic [PTRLEN-1:0]   wr_ptr_next_s;
  logic [PTRLEN:0]     push_cnt_s;
  logic [PTRLEN:0]     occ_next_s;

  // BR_NOP is excluded even when flagged mispredicted.
  function automatic logic is_useful(input logic [2:0] typ, input logic mispred);
    return (typ != BR_NOP) && ((typ == BR_COND) || mispred);
  endfunction

  // Lane filtering, write addressing and next occupancy.
  always_comb begin
    lane0_s       = '{pc: push_pc_0, target: push_target_0, typ: push_type_0,
                      taken: push_taken_0, mispred: push_mispred_0};
    lane1_s       = '{pc: push_pc_1, target: push_target_1, typ: push_type_1,
                      taken: push_taken_1, mispred: push_mispred_1};
    useful0_s     = push_valid_0 && push_ready && is_useful(push_type_0, push_mispred_0);
    useful1_s     = push_valid_1 && push_ready && is_useful(push_type_1, push_mispred_1);
    pop_s         = (occupancy != '0);
    head_s        = mem_r[rd_ptr_r];
    wr_ptr1_s     = wr_ptr_r + PTRLEN'(useful0_s);
    push_cnt_s    = (PTRLEN+1)'(useful0_s) + (PTRLEN+1)'(useful1_s);
    wr_ptr_next_s = wr_ptr_r + PTRLEN'(push_cnt_s);
    occ_next_s    = occupancy + push_cnt_s - (PTRLEN+1)'(pop_s);
  end

  // Entry storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (useful0_s) begin
        mem_r[wr_ptr_r] <= lane0_s;
      end
      if (useful1_s) begin
        mem_r[wr_ptr1_s] <= lane1_s;
      end
    end
  end

  // Pointers, occupancy, readiness and the registered predictor update port.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r        <= '0;
      rd_ptr_r        <= '0;
      occupancy       <= '0;
      push_ready      <= 1'b1;
      update_orien_en <= 1'b0;
      retire_pc       <= 32'h0000_0000;
      right_orien     <= 1'b0;
      branch_mistaken <= 1'b0;
      wrong_pc        <= 32'h0000_0000;
      right_target    <= 32'h0000_0000;
      ins_type_w      <= 3'd0;
    end else begin
      wr_ptr_r   <= wr_ptr_next_s;
      occupancy  <= occ_next_s;
      push_ready <= (occ_next_s <= READY_MAX);
      if (pop_s) begin
        rd_ptr_r        <= rd_ptr_r + PTRLEN'(1);
        update_orien_en <= (head_s.typ == BR_COND);
        retire_pc       <= head_s.pc;
        right_orien     <= head_s.taken;
        branch_mistaken <= head_s.mispred;
        wrong_pc        <= head_s.pc;
        right_target    <= head_s.target;
        ins_type_w      <= head_s.typ;
      end else begin
        // Empty: drop the enables, keep the data fields as they were.
        update_orien_en <= 1'b0;
        branch_mistaken <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pred_update_queue.sv
// Randomized and directed bench for pred_update_queue, checked every cycle against a
// queue-based reference model of the filter/FIFO/drain behaviour.
module tb_pred_update_queue;

  localparam int DEPTH = 8;
  localparam logic [2:0] T_NOP  = 3'd0;
  localparam logic [2:0] T_COND = 3'd1;
  localparam logic [2:0] T_CALL = 3'd2;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  typ;
    logic        taken;
    logic [31:0] target;
    logic        mispred;
  } lane_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        push_valid_0, push_taken_0, push_mispred_0;
  logic [31:0] push_pc_0, push_target_0;
  logic [2:0]  push_type_0;
  logic        push_valid_1, push_taken_1, push_mispred_1;
  logic [31:0] push_pc_1, push_target_1;
  logic [2:0]  push_type_1;
  logic        push_ready, update_orien_en, right_orien, branch_mistaken;
  logic [31:0] retire_pc, wrong_pc, right_target;
  logic [2:0]  ins_type_w;
  logic [3:0]  occupancy;

  pred_update_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .push_valid_0(push_valid_0), .push_pc_0(push_pc_0), .push_type_0(push_type_0),
    .push_taken_0(push_taken_0), .push_target_0(push_target_0), .push_mispred_0(push_mispred_0),
    .push_valid_1(push_valid_1), .push_pc_1(push_pc_1), .push_type_1(push_type_1),
    .push_taken_1(push_taken_1), .push_target_1(push_target_1), .push_mispred_1(push_mispred_1),
    .push_ready(push_ready), .update_orien_en(update_orien_en), .retire_pc(retire_pc),
    .right_orien(right_orien), .branch_mistaken(branch_mistaken), .wrong_pc(wrong_pc),
    .right_target(right_target), .ins_type_w(ins_type_w), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int popped   = 0;

  lane_t l0, l1, idle;
  logic  rst_req;
  lane_t q[$];

  logic        e_orien, e_rorien, e_mis, e_ready;
  logic [31:0] e_rpc, e_wpc, e_tgt;
  logic [2:0]  e_type;
  int          e_occ;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic lane_t mk(input logic v, input logic [31:0] pc, input logic [2:0] t,
                               input logic tk, input logic [31:0] tg, input logic mp);
    lane_t r;
    r.valid = v; r.pc = pc; r.typ = t; r.taken = tk; r.target = tg; r.mispred = mp;
    return r;
  endfunction

  function automatic lane_t rnd_lane();
    return mk(1'($urandom_range(0, 1)), 32'h1c00_0000 + 32'($urandom_range(0, 4095) << 2),
              3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
              32'h1c01_0000 + 32'($urandom_range(0, 4095) << 2), 1'($urandom_range(0, 1)));
  endfunction

  // A branch trains the predictor if it is conditional, or if it was mispredicted and is not a NOP.
  function automatic logic wanted(input lane_t l);
    if (!l.valid || l.typ == T_NOP) return 1'b0;
    return (l.typ == T_COND) || l.mispred;
  endfunction

  task automatic model_edge(input logic rst, input lane_t d0, input lane_t d1);
    lane_t h;
    logic  rdy;
    if (rst) begin
      q.delete();
      e_orien = 0; e_rorien = 0; e_mis = 0; e_rpc = 0; e_wpc = 0; e_tgt = 0; e_type = 0;
    end else begin
      rdy = (q.size() <= DEPTH - 2);
      if (q.size() != 0) begin
        h = q.pop_front();
        popped++;
        e_orien = (h.typ == T_COND); e_rpc = h.pc; e_rorien = h.taken;
        e_mis = h.mispred; e_wpc = h.pc; e_tgt = h.target; e_type = h.typ;
      end else begin
        e_orien = 0; e_mis = 0;
      end
      if (rdy && wanted(d0)) q.push_back(d0);
      if (rdy && wanted(d1)) q.push_back(d1);
    end
    e_occ   = q.size();
    e_ready = (q.size() <= DEPTH - 2);
  endtask

  task automatic step();
    lane_t d0, d1;
    logic  r;
    @(negedge clk);
    d0 = l0; d1 = l1; r = rst_req;
    if (!e_ready) begin
      d0.valid = 1'b0; d1.valid = 1'b0;
    end
    reset = r;
    push_valid_0 = d0.valid; push_pc_0 = d0.pc; push_type_0 = d0.typ;
    push_taken_0 = d0.taken; push_target_0 = d0.target; push_mispred_0 = d0.mispred;
    push_valid_1 = d1.valid; push_pc_1 = d1.pc; push_type_1 = d1.typ;
    push_taken_1 = d1.taken; push_target_1 = d1.target; push_mispred_1 = d1.mispred;
    @(posedge clk);
    model_edge(r, d0, d1);
    #1;
    check_val("occupancy", 32'(occupancy), 32'(e_occ));
    check_val("push_ready", 32'(push_ready), 32'(e_ready));
    check_val("update_orien_en", 32'(update_orien_en), 32'(e_orien));
    check_val("retire_pc", retire_pc, e_rpc);
    check_val("right_orien", 32'(right_orien), 32'(e_rorien));
    check_val("branch_mistaken", 32'(branch_mistaken), 32'(e_mis));
    check_val("wrong_pc", wrong_pc, e_wpc);
    check_val("right_target", right_target, e_tgt);
    check_val("ins_type_w", 32'(ins_type_w), 32'(e_type));
  endtask

  task automatic idle_steps(input int n);
    l0 = idle; l1 = idle;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    idle = mk(1'b0, 32'h0, T_NOP, 1'b0, 32'h0, 1'b0);
    l0 = idle; l1 = idle;
    e_ready = 1'b1;
    reset = 1'b1;
    push_valid_0 = 0; push_pc_0 = 0; push_type_0 = 0; push_taken_0 = 0;
    push_target_0 = 0; push_mispred_0 = 0;
    push_valid_1 = 0; push_pc_1 = 0; push_type_1 = 0; push_taken_1 = 0;
    push_target_1 = 0; push_mispred_1 = 0;

    // Reset state
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    check_val("reset_occupancy", 32'(occupancy), 32'd0);
    check_val("reset_ready", 32'(push_ready), 32'd1);
    check_val("reset_retire_pc", retire_pc, 32'h0);

    // 1: single conditional branch, two-edge latency
    l0 = mk(1'b1, 32'h1c00_0100, T_COND, 1'b1, 32'h1c00_0800, 1'b0);
    step();
    check_val("t1_no_bypass", 32'(update_orien_en), 32'd0);
    l0 = idle;
    step();
    check_val("t1_orien_en", 32'(update_orien_en), 32'd1);
    check_val("t1_retire_pc", retire_pc, 32'h1c00_0100);
    check_val("t1_right_orien", 32'(right_orien), 32'd1);
    check_val("t1_mistaken", 32'(branch_mistaken), 32'd0);
    step();
    check_val("t1_orien_off", 32'(update_orien_en), 32'd0);
    check_val("t1_mis_off", 32'(branch_mistaken), 32'd0);

    // 2: dual push, cond then mispredicted call
    l0 = mk(1'b1, 32'h1c00_0200, T_COND, 1'b0, 32'h1c00_0300, 1'b0);
    l1 = mk(1'b1, 32'h1c00_0204, T_CALL, 1'b1, 32'h1c00_1000, 1'b1);
    step();
    l0 = idle; l1 = idle;
    step();
    check_val("t2_pop1_orien", 32'(update_orien_en), 32'd1);
    check_val("t2_pop1_taken", 32'(right_orien), 32'd0);
    check_val("t2_pop1_mis", 32'(branch_mistaken), 32'd0);
    step();
    check_val("t2_pop2_orien", 32'(update_orien_en), 32'd0);
    check_val("t2_pop2_mis", 32'(branch_mistaken), 32'd1);
    check_val("t2_pop2_target", right_target, 32'h1c00_1000);
    check_val("t2_pop2_type", 32'(ins_type_w), 32'(T_CALL));
    idle_steps(2);

    // 3: correctly predicted call plus mispredicted NOP are both filtered
    l0 = mk(1'b1, 32'h1c00_0400, T_CALL, 1'b1, 32'h1c00_2000, 1'b0);
    l1 = mk(1'b1, 32'h1c00_0404, T_NOP, 1'b0, 32'h1c00_3000, 1'b1);
    step();
    check_val("t3_occupancy", 32'(occupancy), 32'd0);
    idle_steps(3);

    // 4: dual push every cycle from empty, stream 0x1c000000+4k
    begin
      int k = 0;
      for (int i = 0; i < 16; i++) begin
        if (e_ready) begin
          l0 = mk(1'b1, 32'h1c00_0000 + 32'(4 * k), T_COND, 1'(k & 1), 32'h0, 1'b0);
          l1 = mk(1'b1, 32'h1c00_0000 + 32'(4 * (k + 1)), T_COND, 1'((k + 1) & 1), 32'h0, 1'b0);
          k += 2;
        end else begin
          l0 = idle; l1 = idle;
        end
        step();
        if (i < 6) check_val("t4_occ_growth", 32'(occupancy), 32'(i + 2));
        if (i == 5) check_val("t4_ready_drop", 32'(push_ready), 32'd0);
      end
      idle_steps(DEPTH + 2);
      check_val("t4_drained", 32'(occupancy), 32'd0);
    end

    // 5: random mix incl. lane-1-only pushes and pointer wrap
    popped = 0;
    for (int i = 0; i < 300; i++) begin
      l0 = rnd_lane();
      l1 = rnd_lane();
      if ($urandom_range(0, 3) == 0) l0.valid = 1'b0;
      step();
    end
    idle_steps(DEPTH + 2);
    check_val("t5_enough_pops", 32'(popped >= 3 * DEPTH), 32'd1);

    // 6: reset mid-drain with occupancy 5
    for (int i = 0; i < 4; i++) begin
      l0 = mk(1'b1, 32'h1c00_5000 + 32'(8 * i), T_COND, 1'b1, 32'h0, 1'b0);
      l1 = mk(1'b1, 32'h1c00_5004 + 32'(8 * i), T_CALL, 1'b0, 32'h1c00_6000, 1'b1);
      step();
    end
    check_val("t6_occ_before", 32'(occupancy), 32'd5);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    check_val("t6_orien_off", 32'(update_orien_en), 32'd0);
    check_val("t6_mis_off", 32'(branch_mistaken), 32'd0);
    check_val("t6_occupancy", 32'(occupancy), 32'd0);
    check_val("t6_ready", 32'(push_ready), 32'd1);
    l0 = mk(1'b1, 32'h1c00_7000, T_COND, 1'b0, 32'h0, 1'b0);
    step();
    l0 = idle;
    step();
    check_val("t6_post_pc", retire_pc, 32'h1c00_7000);
    check_val("t6_post_orien", 32'(update_orien_en), 32'd1);
    idle_steps(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
